// File: rtl/lfsr_pkg.sv
// Shared types for the LFSR sequencer: controller state encoding and default taps.
// No logic; imported by the controller and the LFSR core.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } lfsr_state_e;

    // x^8 + x^6 + x^5 + x^4 + 1, maximal length for an 8-bit register
    localparam logic [7:0] LFSR_DEFAULT_TAPS = 8'hB8;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Serial output stream of the LFSR sequencer: one bit per valid/ready handshake.
// The producer holds out_bit stable while out_valid is high and out_ready is low.
interface lfsr_seq_ctrl_if;

    logic out_bit;
    logic out_valid;
    logic out_ready;

    modport master (
        output out_bit,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_bit,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: serial load (MSB first) or one feedback step per cycle.
// Single-cycle update; load_en wins over step_en; holds when neither is set.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             load_bit,
    input  logic             step_en,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             feedback;

    always_comb begin
        feedback = ^(state_q & TAPS);
        state_d  = state_q;
        if (load_en) begin
            state_d = {state_q[WIDTH-2:0], load_bit};
        end else if (step_en) begin
            state_d = {state_q[WIDTH-2:0], feedback};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Loads a seed serially into an LFSR, then emits nbits output bits over a valid/ready stream.
// First out_valid WIDTH+1 cycles after start is accepted; output holds while out_ready is low.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEFAULT_TAPS),
    parameter int               CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     seed,
    input  logic [CNT_W-1:0]     nbits,
    lfsr_seq_ctrl_if.master      out_if,
    output logic                 busy,
    output logic                 done,
    output logic                 lockup,
    output logic [WIDTH-1:0]     state_q
);

    localparam int               LDW     = $clog2(WIDTH + 1);
    localparam logic [LDW-1:0]   LD_LAST = LDW'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    lfsr_state_e      st_q,     st_d;
    logic [WIDTH-1:0] seed_q,   seed_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [LDW-1:0]   ld_q,     ld_d;
    logic             lockup_q, lockup_d;
    logic             load_en;
    logic             step_en;
    logic             hs;
    logic [WIDTH-1:0] lfsr_state;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en),
        .load_bit (seed_q[WIDTH-1]),
        .step_en  (step_en),
        .state    (lfsr_state)
    );

    always_comb begin
        st_d     = st_q;
        seed_d   = seed_q;
        cnt_d    = cnt_q;
        ld_d     = ld_q;
        lockup_d = lockup_q;
        load_en  = 1'b0;
        step_en  = 1'b0;
        hs       = (st_q == RUN) && out_if.out_ready && !abort;

        case (st_q)
            IDLE: begin
                if (start) begin
                    st_d     = LOAD;
                    seed_d   = seed;
                    cnt_d    = nbits;
                    ld_d     = '0;
                    lockup_d = 1'b0;
                end
            end
            LOAD: begin
                // WIDTH shift cycles, then one settle cycle that judges the loaded register
                if (abort) begin
                    st_d = IDLE;
                end else if (ld_q != LD_LAST) begin
                    load_en = 1'b1;
                    seed_d  = {seed_q[WIDTH-2:0], 1'b0};
                    ld_d    = ld_q + LDW'(1);
                end else if (lfsr_state == '0) begin
                    lockup_d = 1'b1;
                    st_d     = DONE;
                end else if (cnt_q == '0) begin
                    st_d = DONE;
                end else begin
                    st_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    st_d = IDLE;
                end else if (hs) begin
                    step_en = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                    if (cnt_q == CNT_ONE) begin
                        st_d = DONE;
                    end
                end
            end
            DONE: begin
                st_d = IDLE;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q     <= IDLE;
            seed_q   <= '0;
            cnt_q    <= '0;
            ld_q     <= '0;
            lockup_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            ld_q     <= ld_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_if.out_bit   = lfsr_state[WIDTH-1];
    assign out_if.out_valid = (st_q == RUN);
    assign busy             = (st_q != IDLE);
    assign done             = (st_q == DONE);
    assign lockup           = lockup_q;
    assign state_q          = lfsr_state;

endmodule
